uart_frac_baud_gen: RTL

Parametrised successor to the UART baud-rate tick generator. It divides the system clock by an integer-plus-fraction divisor to produce an oversample tick (OvsTick), and divides that by a parameterised oversample ratio to produce a bit-rate tick (BitTick). It also supports enable and phase restart, so a UART RX can align the bit tick to a detected start edge and a UART TX can share the same block. It sits between the register/config logic and the UART TX/RX engines.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_frac_divider.sv | 50 +++++
 rtl/uart_frac_baud_gen.sv | 45 ++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults for the fractional UART baud generator
package uart_pkg;
  localparam int DIV_W_DEF = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OVS_DEF = 16;
  function automatic int ovs_restart(input int ovs);
    return ovs / 2;
  endfunction
endpackage

// File: rtl/uart_frac_divider.sv
// uart_frac_divider: N + F/2^FRAC_W clock divider producing the oversample tick
module uart_frac_divider import uart_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              restart,
  input  logic [DIV_W-1:0]  divisor,
  input  logic [FRAC_W-1:0] frac,
  output logic              ovs_tick,
  output logic              config_err
);
  localparam logic [DIV_W:0] CNT_ONE = {{DIV_W{1'b0}}, 1'b1};
  logic [DIV_W:0] clk_cnt;
  logic [DIV_W-1:0] n_q;
  logic [FRAC_W-1:0] f_q;
  logic [FRAC_W-1:0] acc;
  logic c;
  logic idle;
  logic hit;
  logic load;
  always_comb begin
    idle = n_q == '0;
    hit = clk_cnt == {1'b0, n_q} + {{DIV_W{1'b0}}, c};
    ovs_tick = !rst && !restart && !idle && enable && hit;
    config_err = !rst && idle;
    load = rst || restart || idle || !enable || ovs_tick;
  end
  // shadows only move between periods, so a mid-period divisor change waits its turn
  always_ff @(posedge clk) begin
    if (load) begin
      n_q <= divisor;
      f_q <= frac;
    end
    if (rst || restart) begin
      clk_cnt <= CNT_ONE;
      acc <= '0;
      c <= 1'b0;
    end else if (idle) begin
      clk_cnt <= CNT_ONE;
    end else if (ovs_tick) begin
      clk_cnt <= CNT_ONE;
      {c, acc} <= {1'b0, acc} + {1'b0, f_q};
    end else if (enable) begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_frac_baud_gen.sv
// uart_frac_baud_gen: fractional oversample tick plus bit tick and oversample phase
module uart_frac_baud_gen import uart_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OVS = OVS_DEF
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Enable,
  input  logic                    Restart,
  input  logic [DIV_W-1:0]        Divisor,
  input  logic [FRAC_W-1:0]       Frac,
  output logic                    OvsTick,
  output logic                    BitTick,
  output logic [$clog2(OVS)-1:0]  BitPhase,
  output logic                    ConfigErr
);
  localparam int OVS_W = $clog2(OVS);
  localparam logic [OVS_W-1:0] PH_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] PH_RESTART = OVS_W'(ovs_restart(OVS));
  logic [OVS_W-1:0] ovs_cnt;
  uart_frac_divider #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_div (
    .clk(Clk),
    .rst(Rst),
    .enable(Enable),
    .restart(Restart),
    .divisor(Divisor),
    .frac(Frac),
    .ovs_tick(OvsTick),
    .config_err(ConfigErr)
  );
  // restart lands mid-bit so the RX samples at the centre of each bit
  always_ff @(posedge Clk) begin
    if (Rst)
      ovs_cnt <= '0;
    else if (Restart)
      ovs_cnt <= PH_RESTART;
    else if (OvsTick)
      ovs_cnt <= ovs_cnt == PH_LAST ? '0 : ovs_cnt + 1'b1;
  end
  always_comb begin
    BitTick = OvsTick && ovs_cnt == PH_LAST;
    BitPhase = Rst ? '0 : ovs_cnt;
  end
endmodule
